// File: rtl/addsub_serial_if.sv
// addsub_serial_if: operand/result handshake bundle (master drives operands, mode bits and out_ready; slave returns in_ready, S, flags and out_valid)
interface addsub_serial_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             addsub;
  logic             sat;
  logic             acc;
  logic             clr_acc;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ov_flag;
  logic             zero_flag;
  logic             out_valid;
  logic             out_ready;
  modport master (
    output in_valid, A, B, addsub, sat, acc, clr_acc, out_ready,
    input  in_ready, S, cout, ov_flag, zero_flag, out_valid
  );
  modport slave (
    input  in_valid, A, B, addsub, sat, acc, clr_acc, out_ready,
    output in_ready, S, cout, ov_flag, zero_flag, out_valid
  );
endinterface

// File: rtl/addsub_serial.sv
// addsub_serial: slice-serial add/sub with accumulator and saturation; ports clk, rst (async high) and bus (slave side of addsub_serial_if)
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic           clk,
  input logic           rst,
  addsub_serial_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_reg, b_reg, r_reg, acc_reg, s_raw, s_fin;
  logic [WIDTH+SLICE-1:0] r_cat;
  logic [SLICE:0] sum;
  logic [CW-1:0] cnt;
  logic carry, sat_r, acc_r, last, a_msb, b_msb, ov;
  assign last = cnt == CW'(NSLICE - 1);
  assign sum = {1'b0, a_reg[SLICE-1:0]} + {1'b0, b_reg[SLICE-1:0]} + (SLICE+1)'(carry);
  assign r_cat = {sum[SLICE-1:0], r_reg};
  assign s_raw = r_cat[WIDTH+SLICE-1:SLICE];
  assign a_msb = a_reg[SLICE-1];
  assign b_msb = b_reg[SLICE-1];
  assign ov = (a_msb == b_msb) && (sum[SLICE-1] != a_msb);
  assign s_fin = sat_r && ov ? (a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : s_raw;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.in_valid ? CALC : IDLE) :
              state == CALC ? (last ? DONE : CALC) :
              (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      r_reg <= '0;
      acc_reg <= '0;
      cnt <= '0;
      carry <= 1'b0;
      sat_r <= 1'b0;
      acc_r <= 1'b0;
      bus.S <= '0;
      bus.cout <= 1'b0;
      bus.ov_flag <= 1'b0;
      bus.zero_flag <= 1'b0;
    end else begin
      if (state == IDLE && bus.clr_acc) acc_reg <= '0;
      if (state == IDLE && bus.in_valid) begin
        a_reg <= bus.acc ? (bus.clr_acc ? '0 : acc_reg) : bus.A;
        b_reg <= bus.addsub ? ~bus.B : bus.B;
        carry <= bus.addsub;
        cnt <= '0;
        sat_r <= bus.sat;
        acc_r <= bus.acc;
      end
      if (state == CALC) begin
        a_reg <= a_reg >> SLICE;
        b_reg <= b_reg >> SLICE;
        r_reg <= s_raw;
        carry <= sum[SLICE];
        cnt <= cnt + CW'(1);
        if (last) begin
          bus.S <= s_fin;
          bus.cout <= sum[SLICE];
          bus.ov_flag <= ov;
          bus.zero_flag <= s_fin == '0;
          if (acc_r) acc_reg <= s_fin;
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: scoreboard bench for addsub_serial at WIDTH=16, SLICE=4
module tb_addsub_serial;
  localparam int W = 16, SL = 4, NS = 4;
  typedef struct packed {logic [15:0] s; logic c; logic v; logic z;} res_t;
  logic clk = 1'b0;
  logic rst;
  int passed = 0, total = 0, cyc = 0;
  res_t sbq[$];
  logic [15:0] acc_m = 16'h0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  addsub_serial_if #(.WIDTH(W)) bus();
  addsub_serial #(.WIDTH(W), .SLICE(SL)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic sat);
    res_t r;
    logic [16:0] u;
    int sa, sb, t;
    u = {1'b0, a} + {1'b0, b};
    r.c = sub ? (a >= b) : u[16];
    r.s = sub ? a - b : a + b;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t = sub ? sa - sb : sa + sb;
    r.v = t > 32767 || t < -32768;
    if (sat && r.v) r.s = t < 0 ? 16'h8000 : 16'h7FFF;
    r.z = r.s == 16'h0;
    return r;
  endfunction
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic sat,
                        input logic ac, input logic clr, input logic clr_mid, output res_t o, output int lat);
    res_t e;
    e = model(ac ? (clr ? 16'h0 : acc_m) : a, b, sub, sat);
    if (clr) acc_m = 16'h0;
    if (ac) acc_m = e.s;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.addsub = sub; bus.sat = sat; bus.acc = ac; bus.clr_acc = clr;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.acc = 1'b0; bus.clr_acc = clr_mid;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.clr_acc = 1'b0;
    o = {bus.S, bus.cout, bus.ov_flag, bus.zero_flag};
  endtask
  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    else passed++;
    total++;
    if ({bus.S, bus.cout, bus.ov_flag, bus.zero_flag} !== 19'h0) $display("FAIL reset_out: got S=%h c=%b v=%b z=%b want all 0", bus.S, bus.cout, bus.ov_flag, bus.zero_flag);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL post_reset: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    else passed++;
  endtask
  task automatic test_add;
    res_t o, e;
    int lat;
    run_op(16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o, lat);
    e = sbq.pop_front();
    total++;
    if (o !== e || o.s !== 16'h0003) $display("FAIL add: got %h want %h", o, e);
    else passed++;
    total++;
    if (lat !== NS) $display("FAIL add_latency: got %0d want %0d", lat, NS);
    else passed++;
  endtask
  task automatic test_sub;
    logic [15:0] av[2] = '{16'h0016, 16'h0016};
    logic [15:0] bv[2] = '{16'h000A, 16'h001A};
    logic [15:0] sv[2] = '{16'h000C, 16'hFFFC};
    logic cv[2] = '{1'b1, 1'b0};
    res_t o, e;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(av[i], bv[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o, lat);
      e = sbq.pop_front();
      total++;
      if (o !== e || o.s !== sv[i] || o.c !== cv[i] || o.v !== 1'b0) $display("FAIL sub%0d: got %h want %h", i, o, e);
      else passed++;
    end
  endtask
  task automatic test_overflow;
    logic [15:0] av[3] = '{16'h7FFF, 16'h7FFF, 16'h8000};
    logic sub_v[3] = '{1'b0, 1'b0, 1'b1};
    logic sat_v[3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] sv[3] = '{16'h8000, 16'h7FFF, 16'h8000};
    logic cv[3] = '{1'b0, 1'b0, 1'b1};
    res_t o, e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], 16'h0001, sub_v[i], sat_v[i], 1'b0, 1'b0, 1'b0, o, lat);
      e = sbq.pop_front();
      total++;
      if (o !== e || o.s !== sv[i] || o.v !== 1'b1 || o.c !== cv[i]) $display("FAIL overflow%0d: got %h want %h", i, o, e);
      else passed++;
    end
  endtask
  task automatic test_random;
    res_t o, e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, o, lat);
      e = sbq.pop_front();
      total++;
      if (o !== e || lat !== NS) $display("FAIL random%0d: got %h lat %0d want %h lat %0d", i, o, lat, e, NS);
      else passed++;
    end
  endtask
  task automatic test_acc;
    logic [15:0] bv[6] = '{16'd5, 16'd7, 16'd12, 16'd9, 16'd1, 16'd2};
    logic sub_v[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic clr_v[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic mid_v[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] sv[6] = '{16'd5, 16'd12, 16'd0, 16'd9, 16'd10, 16'd12};
    res_t o, e;
    int lat;
    @(posedge clk); #1;
    bus.clr_acc = 1'b1;
    @(posedge clk); #1;
    bus.clr_acc = 1'b0;
    acc_m = 16'h0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, o, lat);
      if (i == 3) e = sbq.pop_front();
      run_op(16'hA5A5, bv[i], sub_v[i], 1'b0, 1'b1, clr_v[i], mid_v[i], o, lat);
      e = sbq.pop_front();
      total++;
      if (o !== e || o.s !== sv[i]) $display("FAIL acc%0d: got %h want %h", i, o, e);
      else passed++;
    end
    total++;
    if (o.z !== 1'b0 || acc_m !== 16'd12) $display("FAIL acc_end: z=%b acc=%h want 0 000c", o.z, acc_m);
    else passed++;
  endtask
  task automatic test_back_to_back;
    res_t o, e;
    int n, t[2];
    e = model(16'h1234, 16'h0101, 1'b0, 1'b0);
    sbq.push_back(e);
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.A = 16'h1234; bus.B = 16'h0101; bus.addsub = 1'b0; bus.sat = 1'b0; bus.acc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!bus.out_valid && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      t[k] = cyc;
      o = {bus.S, bus.cout, bus.ov_flag, bus.zero_flag};
      e = sbq.pop_front();
      total++;
      if (o !== e) $display("FAIL b2b%0d: got %h want %h", k, o, e);
      else passed++;
      if (k == 1) bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (t[1] - t[0] !== NS + 2) $display("FAIL b2b_period: got %0d want %0d", t[1] - t[0], NS + 2);
    else passed++;
  endtask
  task automatic test_backpressure;
    res_t o, o2, e;
    int lat;
    bus.out_ready = 1'b0;
    run_op(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o, lat);
    e = sbq.pop_front();
    total++;
    if (o !== e) $display("FAIL bp_result: got %h want %h", o, e);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0] ? 1'b0 : 1'b1;
      bus.A = 16'hFFFF;
      bus.B = 16'h1111;
      @(posedge clk); #1;
      o2 = {bus.S, bus.cout, bus.ov_flag, bus.zero_flag};
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || o2 !== e) $display("FAIL bp_hold%0d: ov=%b ir=%b res=%h want 1 0 %h", i, bus.out_valid, bus.in_ready, o2, e);
      else passed++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    o2 = {bus.S, bus.cout, bus.ov_flag, bus.zero_flag};
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || o2 !== e) $display("FAIL bp_release: ov=%b ir=%b res=%h want 0 1 %h", bus.out_valid, bus.in_ready, o2, e);
    else passed++;
  endtask
  task automatic test_reset_mid;
    res_t o, e;
    int lat, seen;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.B = 16'h0010; bus.addsub = 1'b0; bus.sat = 1'b0; bus.acc = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.acc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m = 16'h0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    total++;
    if (seen !== 0 || bus.S !== 16'h0) $display("FAIL rst_mid_abandon: out_valid cycles=%0d S=%h want 0 0000", seen, bus.S);
    else passed++;
    run_op(16'hFFFF, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, o, lat);
    e = sbq.pop_front();
    total++;
    if (o !== e || o.s !== 16'h0003) $display("FAIL rst_mid_acc: got %h want %h", o, e);
    else passed++;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.addsub = 1'b0; bus.sat = 1'b0;
    bus.acc = 1'b0; bus.clr_acc = 1'b0; bus.out_ready = 1'b1;
    test_reset;
    test_add;
    test_sub;
    test_overflow;
    test_random;
    test_acc;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
